// File: rtl/bin_to_bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encodings, digit constants and the saturation limit helper.
package bin_to_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX_DIGIT  = 4'd9;
    localparam logic [3:0] ADD3_THRESHOLD = 4'd5;

    // Largest value representable in the given number of decimal digits (10^n - 1).
    function automatic logic [63:0] bcd_max_value(input int n);
        logic [63:0] v;
        v = 64'd1;
        for (int i = 0; i < n; i++) begin
            v = v * 64'd10;
        end
        return v - 64'd1;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// Combinational double-dabble correction for one BCD digit (add 3 when >= 5).
module bcd_digit_adj
    import bin_to_bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adj
);

    assign adj = (digit >= ADD3_THRESHOLD) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock, with saturation.
// Optional leading-zero blanking is enabled with macro BIN_TO_BCD_LEADING_BLANK_EN.
//
// state | meaning
// IDLE  | waiting for start; bin captured when start is accepted
// SHIFT | one add-3/shift step per clock, WIDTH steps in total
// DONE  | register bcd/overflow/blank, pulse done, drop busy
module bin_to_bcd_seq
    import bin_to_bcd_pkg::*;
#(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow,
    output logic [DIGITS-1:0]     blank
);

    localparam int SR_W  = 4*DIGITS + WIDTH;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [63:0] MAX_VALUE = bcd_max_value(DIGITS);

    state_t               state;
    logic [SR_W-1:0]      sr;
    logic [SR_W-1:0]      sr_next;
    logic [WIDTH-1:0]     bin_q;
    logic [CNT_W-1:0]     bit_cnt;
    logic [4*DIGITS-1:0]  adj_digits;
    logic [4*DIGITS-1:0]  final_digits;
    logic [DIGITS-1:0]    blank_c;
    logic                 ovf_c;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit (sr[WIDTH + 4*g +: 4]),
            .adj   (adj_digits[4*g +: 4])
        );
    end

    // The digit field's top bit falls off the shift; any value that reaches it
    // already exceeds the digit range and is replaced by saturation below.
    assign sr_next = SR_W'({adj_digits, sr[WIDTH-1:0], 1'b0});

    assign ovf_c        = 64'(bin_q) > MAX_VALUE;
    assign final_digits = ovf_c ? {DIGITS{BCD_MAX_DIGIT}} : sr[SR_W-1 -: 4*DIGITS];

`ifdef BIN_TO_BCD_LEADING_BLANK_EN
    logic seen_nonzero;

    always_comb begin
        blank_c      = '0;
        seen_nonzero = 1'b0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (final_digits[4*k +: 4] != 4'd0) begin
                seen_nonzero = 1'b1;
            end
            blank_c[k] = !seen_nonzero;
        end
    end
`else
    assign blank_c = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
            blank    <= '0;
            sr       <= '0;
            bin_q    <= '0;
            bit_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_q   <= bin;
                        sr      <= {{(4*DIGITS){1'b0}}, bin};
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr <= sr_next;
                    if (bit_cnt == LAST_BIT) begin
                        state <= DONE;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DONE: begin
                    bcd      <= final_digits;
                    overflow <= ovf_c;
                    blank    <= blank_c;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq at WIDTH=14, DIGITS=4.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [13:0] bin = '0;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        overflow;
    logic [3:0]  blank;

    int total = 0;
    int bad   = 0;

`ifdef BIN_TO_BCD_LEADING_BLANK_EN
    localparam logic [3:0] BLANK_ZERO = 4'b1110;
    localparam logic [3:0] BLANK_60   = 4'b1100;
    localparam logic [3:0] BLANK_88   = 4'b1100;
`else
    localparam logic [3:0] BLANK_ZERO = 4'b0000;
    localparam logic [3:0] BLANK_60   = 4'b0000;
    localparam logic [3:0] BLANK_88   = 4'b0000;
`endif

    bin_to_bcd_seq #(.WIDTH(14), .DIGITS(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .overflow (overflow),
        .blank    (blank)
    );

    always #5 clk = ~clk;

    // Present start for one edge; returns 1ns after the accepting edge (clock 0).
    task automatic kick(input logic [13:0] v);
        @(negedge clk);
        start = 1'b1;
        bin   = v;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts clocks until done is seen, bounded at 40.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 40);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy, done, overflow, blank, bcd} !== 23'd0) begin
            bad++;
            $display("FAIL reset_state: got busy=%b done=%b ovf=%b blank=%b bcd=%h, want all 0",
                     busy, done, overflow, blank, bcd);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_zero();
        int n;
        kick(14'd0);
        wait_done(n);
        total++;
        if (n !== 15) begin
            bad++;
            $display("FAIL zero_latency: got %0d clocks, want 15", n);
        end
        total++;
        if (bcd !== 16'h0000 || overflow !== 1'b0 || blank !== BLANK_ZERO) begin
            bad++;
            $display("FAIL zero_result: got bcd=%h ovf=%b blank=%b, want 0000 0 %b",
                     bcd, overflow, blank, BLANK_ZERO);
        end
        @(posedge clk);
        #1;
        total++;
        if (done !== 1'b0 || bcd !== 16'h0000) begin
            bad++;
            $display("FAIL zero_pulse_hold: got done=%b bcd=%h, want 0 0000", done, bcd);
        end
    endtask

    task automatic test_max_in_range();
        int busy_bad;
        busy_bad = 0;
        kick(14'd9999);
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b1 || done !== 1'b0) busy_bad++;
        end
        total++;
        if (busy_bad !== 0) begin
            bad++;
            $display("FAIL busy_window: got %0d bad clocks among 1-14, want 0", busy_bad);
        end
        @(posedge clk);
        #1;
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL done_at_15: got done=%b busy=%b, want 1 0", done, busy);
        end
        total++;
        if (bcd !== 16'h9999 || overflow !== 1'b0 || blank !== 4'b0000) begin
            bad++;
            $display("FAIL r9999: got bcd=%h ovf=%b blank=%b, want 9999 0 0000", bcd, overflow, blank);
        end
    endtask

    task automatic test_overflow_back_to_back();
        int n;
        kick(14'd10000);
        wait_done(n);
        total++;
        if (n !== 15 || bcd !== 16'h9999 || overflow !== 1'b1 || blank !== 4'b0000) begin
            bad++;
            $display("FAIL overflow_10000: got n=%0d bcd=%h ovf=%b blank=%b, want 15 9999 1 0000",
                     n, bcd, overflow, blank);
        end
        kick(14'd60);
        wait_done(n);
        total++;
        if (n !== 15) begin
            bad++;
            $display("FAIL b2b_latency: got %0d clocks, want 15", n);
        end
        total++;
        if (bcd !== 16'h0060 || overflow !== 1'b0 || blank !== BLANK_60) begin
            bad++;
            $display("FAIL b2b_60: got bcd=%h ovf=%b blank=%b, want 0060 0 %b",
                     bcd, overflow, blank, BLANK_60);
        end
        kick(14'd16383);
        wait_done(n);
        total++;
        if (bcd !== 16'h9999 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL overflow_16383: got bcd=%h ovf=%b, want 9999 1", bcd, overflow);
        end
    endtask

    task automatic test_ignore_start();
        int pulses;
        int pulse_clk;
        logic [15:0] bcd_at;
        pulses    = 0;
        pulse_clk = 0;
        bcd_at    = '0;
        kick(14'd1234);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        bin   = 14'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 6; k <= 35; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                pulses++;
                pulse_clk = k;
                bcd_at    = bcd;
            end
        end
        total++;
        if (pulses !== 1 || pulse_clk !== 15) begin
            bad++;
            $display("FAIL ignore_pulses: got %0d pulses last at clock %0d, want 1 at 15", pulses, pulse_clk);
        end
        total++;
        if (bcd_at !== 16'h1234 || bcd !== 16'h1234) begin
            bad++;
            $display("FAIL ignore_value: got %h (now %h), want 1234", bcd_at, bcd);
        end
    endtask

    task automatic test_reset_abort();
        int n;
        int pulses;
        pulses = 0;
        kick(14'd4321);
        repeat (6) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        total++;
        if ({busy, done, overflow, blank, bcd} !== 23'd0) begin
            bad++;
            $display("FAIL abort_outputs: got busy=%b done=%b ovf=%b blank=%b bcd=%h, want all 0",
                     busy, done, overflow, blank, bcd);
        end
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        total++;
        if (pulses !== 0) begin
            bad++;
            $display("FAIL abort_no_done: got %0d pulses, want 0", pulses);
        end
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        bin   = 14'd77;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_priority: got busy=%b, want 0", busy);
        end
        kick(14'd88);
        wait_done(n);
        total++;
        if (n !== 15 || bcd !== 16'h0088 || overflow !== 1'b0 || blank !== BLANK_88) begin
            bad++;
            $display("FAIL after_abort_88: got n=%0d bcd=%h ovf=%b blank=%b, want 15 0088 0 %b",
                     n, bcd, overflow, blank, BLANK_88);
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_max_in_range();
        test_overflow_back_to_back();
        test_ignore_start();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
